// File: rtl/sd_spi_host.sv
// SPI-mode SD card command host: sends a 6-byte command, collects R1 and an optional
// R3/R7 tail, and can read one 512-byte data block, all over a mode-0 SPI link.
module sd_spi_host #(
    parameter int CLK_DIV = 2,
    parameter int NCR_MAX = 8,
    parameter int TOK_MAX = 1024
) (
    input  logic        clk_50,
    input  logic        reset_n,
    input  logic        cmd_start,
    input  logic [5:0]  cmd_idx,
    input  logic [31:0] cmd_arg,
    input  logic [6:0]  cmd_crc,
    input  logic        resp_ext_en,
    input  logic        rd_block,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [7:0]  resp_r1,
    output logic [31:0] resp_ext,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n
);

    typedef enum logic [3:0] {
        IDLE, PRE, CMD, R1, EXT, TOK, DATA, CRC, POST, DONE
    } state_t;

    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [15:0] NCR_LAST = 16'(NCR_MAX - 1);
    localparam logic [15:0] TOK_LAST = 16'(TOK_MAX - 1);

    state_t      state_q;
    logic [7:0]  divCnt_q;
    logic [3:0]  halfCnt_q;
    logic [9:0]  cnt_q;
    logic [15:0] pollCnt_q;
    logic [5:0]  idx_q;
    logic [31:0] arg_q;
    logic [6:0]  crc_q;
    logic        extEn_q;
    logic        rdBlk_q;
    logic [7:0]  txShift_q;
    logic [7:0]  rxShift_q;
    logic        csN_q;
    logic        sck_q;
    logic        mosi_q;
    logic        busy_q;
    logic        done_q;
    logic        timeout_q;
    logic [7:0]  respR1_q;
    logic [31:0] respExt_q;
    logic [7:0]  rdData_q;
    logic        rdValid_q;

    logic [7:0]  rxByte_d;
    logic [7:0]  cmdByte_d;

    assign rxByte_d = {rxShift_q[6:0], spi_miso};

    // Command byte that follows the one whose index is in cnt_q
    always_comb begin
        cmdByte_d = 8'hFF;
        case (cnt_q[2:0])
            3'd0:    cmdByte_d = arg_q[31:24];
            3'd1:    cmdByte_d = arg_q[23:16];
            3'd2:    cmdByte_d = arg_q[15:8];
            3'd3:    cmdByte_d = arg_q[7:0];
            3'd4:    cmdByte_d = {crc_q, 1'b1};
            default: cmdByte_d = 8'hFF;
        endcase
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            divCnt_q  <= '0;
            halfCnt_q <= '0;
            cnt_q     <= '0;
            pollCnt_q <= '0;
            idx_q     <= '0;
            arg_q     <= '0;
            crc_q     <= '0;
            extEn_q   <= 1'b0;
            rdBlk_q   <= 1'b0;
            txShift_q <= 8'hFF;
            rxShift_q <= 8'hFF;
            csN_q     <= 1'b1;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            respR1_q  <= 8'hFF;
            respExt_q <= '0;
            rdData_q  <= '0;
            rdValid_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            rdValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    csN_q  <= 1'b1;
                    sck_q  <= 1'b0;
                    mosi_q <= 1'b1;
                    if (cmd_start) begin
                        idx_q     <= cmd_idx;
                        arg_q     <= cmd_arg;
                        crc_q     <= cmd_crc;
                        extEn_q   <= resp_ext_en;
                        rdBlk_q   <= rd_block;
                        busy_q    <= 1'b1;
                        timeout_q <= 1'b0;
                        respR1_q  <= 8'hFF;
                        respExt_q <= '0;
                        txShift_q <= 8'hFF;
                        divCnt_q  <= '0;
                        halfCnt_q <= '0;
                        state_q   <= PRE;
                    end
                end
                DONE: state_q <= IDLE;
                default: begin
                    // Even half-periods end with a rising SCK (sample), odd ones with a falling SCK (shift)
                    if (divCnt_q == DIV_LAST) begin
                        divCnt_q  <= '0;
                        halfCnt_q <= halfCnt_q + 4'd1;
                        if (!halfCnt_q[0]) begin
                            sck_q     <= 1'b1;
                            rxShift_q <= rxByte_d;
                            if (state_q == DATA && halfCnt_q == 4'd14) begin
                                rdData_q  <= rxByte_d;
                                rdValid_q <= 1'b1;
                            end
                        end else begin
                            sck_q <= 1'b0;
                            if (halfCnt_q != 4'd15) begin
                                txShift_q <= {txShift_q[6:0], 1'b1};
                                mosi_q    <= txShift_q[6];
                            end else begin
                                txShift_q <= 8'hFF;
                                mosi_q    <= 1'b1;
                                case (state_q)
                                    PRE: begin
                                        state_q   <= CMD;
                                        csN_q     <= 1'b0;
                                        cnt_q     <= '0;
                                        txShift_q <= {2'b01, idx_q};
                                        mosi_q    <= 1'b0;
                                    end
                                    CMD: begin
                                        if (cnt_q == 10'd5) begin
                                            state_q   <= R1;
                                            pollCnt_q <= '0;
                                        end else begin
                                            cnt_q     <= cnt_q + 10'd1;
                                            txShift_q <= cmdByte_d;
                                            mosi_q    <= cmdByte_d[7];
                                        end
                                    end
                                    R1: begin
                                        if (!rxShift_q[7]) begin
                                            respR1_q  <= rxShift_q;
                                            pollCnt_q <= '0;
                                            cnt_q     <= '0;
                                            if (extEn_q) begin
                                                state_q <= EXT;
                                            end else if (rdBlk_q && rxShift_q == 8'h00) begin
                                                state_q <= TOK;
                                            end else begin
                                                state_q <= POST;
                                                csN_q   <= 1'b1;
                                            end
                                        end else if (pollCnt_q == NCR_LAST) begin
                                            respR1_q  <= rxShift_q;
                                            timeout_q <= 1'b1;
                                            state_q   <= POST;
                                            csN_q     <= 1'b1;
                                        end else begin
                                            pollCnt_q <= pollCnt_q + 16'd1;
                                        end
                                    end
                                    EXT: begin
                                        respExt_q <= {respExt_q[23:0], rxShift_q};
                                        if (cnt_q == 10'd3) begin
                                            if (rdBlk_q && respR1_q == 8'h00) begin
                                                state_q <= TOK;
                                            end else begin
                                                state_q <= POST;
                                                csN_q   <= 1'b1;
                                            end
                                        end else begin
                                            cnt_q <= cnt_q + 10'd1;
                                        end
                                    end
                                    TOK: begin
                                        if (rxShift_q == 8'hFE) begin
                                            state_q <= DATA;
                                            cnt_q   <= '0;
                                        end else if (pollCnt_q == TOK_LAST) begin
                                            timeout_q <= 1'b1;
                                            state_q   <= POST;
                                            csN_q     <= 1'b1;
                                        end else begin
                                            pollCnt_q <= pollCnt_q + 16'd1;
                                        end
                                    end
                                    DATA: begin
                                        if (cnt_q == 10'd511) begin
                                            state_q <= CRC;
                                            cnt_q   <= '0;
                                        end else begin
                                            cnt_q <= cnt_q + 10'd1;
                                        end
                                    end
                                    CRC: begin
                                        if (cnt_q == 10'd1) begin
                                            state_q <= POST;
                                            csN_q   <= 1'b1;
                                        end else begin
                                            cnt_q <= cnt_q + 10'd1;
                                        end
                                    end
                                    POST: begin
                                        state_q <= DONE;
                                        done_q  <= 1'b1;
                                        busy_q  <= 1'b0;
                                    end
                                    default: state_q <= IDLE;
                                endcase
                            end
                        end
                    end else begin
                        divCnt_q <= divCnt_q + 8'd1;
                    end
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign timeout  = timeout_q;
    assign resp_r1  = respR1_q;
    assign resp_ext = respExt_q;
    assign rd_data  = rdData_q;
    assign rd_valid = rdValid_q;
    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = csN_q;

endmodule

// File: doc/sd_spi_host.md
SD_SPI_HOST -- requirements
Module: sd_spi_host

Interface
REQ-001 Parameter CLK_DIV, default 2: SCK half-period in clk_50 cycles, legal range 1..255.
REQ-002 Parameter NCR_MAX, default 8: maximum number of bytes polled for the R1 response.
REQ-003 Parameter TOK_MAX, default 1024: maximum number of bytes polled for the 0xFE start-block token.
REQ-004 clk_50  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 cmd_start  in  1  one-cycle request, sampled only in IDLE.
REQ-007 cmd_idx  in  6  command index; cmd_arg  in  32  argument; cmd_crc  in  7  CRC7.
REQ-008 resp_ext_en  in  1  when set, read 4 bytes after R1 (R3/R7).
REQ-009 rd_block  in  1  when set, read one 512-byte data block after R1.
REQ-010 busy  out  1  high from accepted cmd_start until done.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 timeout  out  1  qualifies done: R1 or token not received.
REQ-013 resp_r1  out  8  last R1 byte; resp_ext  out  32  extra bytes, MSB-first.
REQ-014 rd_data  out  8  block byte; rd_valid  out  1  one-cycle strobe per byte.
REQ-015 spi_sck  out  1; spi_mosi  out  1; spi_miso  in  1; spi_cs_n  out  1.

Function
REQ-016 SPI mode 0: SCK idles low, MOSI changes after the SCK falling edge, MISO is sampled on the SCK rising edge, MSB first.
REQ-017 One byte SHALL take exactly 16*CLK_DIV clk_50 cycles; the byte engine SHALL shift TX and RX simultaneously.
REQ-018 States: IDLE, PRE, CMD, R1, EXT, TOK, DATA, CRC, POST, DONE.
REQ-019 IDLE: cs_n=1, sck=0, mosi=1; cmd_start SHALL latch idx, arg, crc, resp_ext_en and rd_block, raise busy, and go to PRE.
REQ-020 PRE: one 0xFF byte with cs_n=1; cs_n SHALL fall before the first CMD clock edge.
REQ-021 CMD: 6 bytes {01,idx}, arg[31:24]..arg[7:0], {crc,1}.
REQ-022 R1: transmit 0xFF; the first received byte with bit7=0 SHALL be stored in resp_r1, then go to EXT if resp_ext_en, else TOK if rd_block, else POST.
REQ-023 R1 timeout: after NCR_MAX bytes with bit7=1, resp_r1 SHALL hold the last byte, timeout SHALL be set, and the FSM SHALL go to POST.
REQ-024 EXT: 4 bytes shifted into resp_ext; then TOK if rd_block, else POST.
REQ-025 TOK: poll with 0xFF; 0xFE goes to DATA; TOK_MAX bytes without it sets timeout and goes to POST.
REQ-026 TOK: if R1 is nonzero, skip TOK/DATA/CRC and go to POST without setting timeout.
REQ-027 DATA: 512 bytes; each byte SHALL present rd_data with a one-cycle rd_valid in the cycle after its last bit is sampled; a 10-bit counter is used.
REQ-028 CRC: 2 bytes read and discarded.
REQ-029 POST: cs_n=1, then one 0xFF byte; then DONE.
REQ-030 DONE: done=1 for one cycle, busy=0, return to IDLE.
REQ-031 cmd_start while busy SHALL be ignored.
REQ-032 Inputs SHALL not be re-sampled mid-command; resp_r1 and resp_ext SHALL hold until the next accepted command.
REQ-033 timeout SHALL clear on an accepted cmd_start.

Reset
REQ-034 While reset_n=0, regardless of state: FSM=IDLE, spi_cs_n=1, spi_sck=0, spi_mosi=1, busy=0, done=0, timeout=0, rd_valid=0, resp_r1=FF, resp_ext=0, rd_data=0, all counters 0.
REQ-035 Reset asserted mid-byte SHALL abort at once, with no further SCK edges; after release the block SHALL accept a new cmd_start normally.

Verification
REQ-036 CMD0 (idx 0, arg 0, crc 4A); responder returns FF,FF,01 -> MOSI bytes 40 00 00 00 00 95; resp_r1=01; done with timeout=0; cs_n high for PRE and POST.
REQ-037 CMD8 (arg 000001AA, crc 43, resp_ext_en=1); responder returns 01 00 00 01 AA -> resp_r1=01, resp_ext=000001AA.
REQ-038 MISO held at 1, NCR_MAX=8 -> exactly 8 R1 poll bytes, resp_r1=FF, timeout=1, done, no DATA-phase SCK.
REQ-039 CMD17 (rd_block=1); R1 00, token FE after 3 FF, block of repeating AB CD 45 67 -> 512 rd_valid pulses with data AB,CD,45,67,...; 2 CRC bytes clocked; done with timeout=0.
REQ-040 Reset during DATA byte 100 -> cs_n=1 and sck=0 while reset is low, no further rd_valid; after release CMD0 completes normally.
REQ-041 cmd_start pulsed while busy -> ignored (exactly one done pulse); CLK_DIV=1 and CLK_DIV=4 runs give byte times of 16 and 64 cycles.
